// File: rtl/uart_fifo_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags and a registered level interrupt.
// Four-register window at BASE_ADDR: TXDATA, RXDATA, STATUS, CTRL.
module uart_fifo_periph #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_in_i,
    output logic        tx_out_o,
    output logic        irq_o
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [31:0] AddrTx   = BASE_ADDR;
    localparam logic [31:0] AddrRx   = BASE_ADDR + 32'd4;
    localparam logic [31:0] AddrStat = BASE_ADDR + 32'd8;
    localparam logic [31:0] AddrCtrl = BASE_ADDR + 32'd12;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic sel_tx, sel_rx, sel_stat, sel_ctrl;
    assign sel_tx   = (addr_i == AddrTx);
    assign sel_rx   = (addr_i == AddrRx);
    assign sel_stat = (addr_i == AddrStat);
    assign sel_ctrl = (addr_i == AddrCtrl);

    logic unused_wdata;
    assign unused_wdata = ^wdata_i[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   tx_wptr_q, tx_rptr_q;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic            tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]      tx_head;

    assign tx_full  = (tx_cnt_q == DepthCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = wr_i & sel_tx & ~tx_full;
    assign tx_head  = tx_mem_q[tx_rptr_q];

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ---------------- TX FSM ----------------
    state_e        tx_state_q;
    logic [CW-1:0] tx_tmr_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_out_q, tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_tmr_q == BitLast);
    assign tx_busy    = (tx_state_q != StIdle);
    // Reload straight from STOP so consecutive bytes leave no idle gap.
    assign tx_pop     = ~tx_empty &
                        ((tx_state_q == StIdle) | ((tx_state_q == StStop) & tx_bit_end));
    assign tx_out_o   = tx_out_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= StIdle;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            unique case (tx_state_q)
                StIdle: begin
                    tx_tmr_q <= '0;
                    tx_out_q <= 1'b1;
                    if (tx_pop) begin
                        tx_shift_q <= tx_head;
                        tx_out_q   <= 1'b0;
                        tx_state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tx_bit_end) begin
                        tx_tmr_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_out_q   <= tx_shift_q[0];
                        tx_state_q <= StData;
                    end else begin
                        tx_tmr_q <= tx_tmr_q + 1'b1;
                    end
                end
                StData: begin
                    if (tx_bit_end) begin
                        tx_tmr_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_out_q   <= 1'b1;
                            tx_state_q <= StStop;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_out_q   <= tx_shift_q[1];
                        end
                    end else begin
                        tx_tmr_q <= tx_tmr_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tx_bit_end) begin
                        tx_tmr_q <= '0;
                        if (tx_pop) begin
                            tx_shift_q <= tx_head;
                            tx_out_q   <= 1'b0;
                            tx_state_q <= StStart;
                        end else begin
                            tx_out_q   <= 1'b1;
                            tx_state_q <= StIdle;
                        end
                    end else begin
                        tx_tmr_q <= tx_tmr_q + 1'b1;
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q, rx_s, rx_fall;
    state_e        rx_state_q;
    logic [CW-1:0] rx_tmr_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_bit_end, rx_push, rx_frame_bad;

    assign rx_s         = rx_sync_q[1];
    assign rx_fall      = rx_prev_q & ~rx_s;
    assign rx_bit_end   = (rx_tmr_q == BitLast);
    assign rx_push      = (rx_state_q == StStop) & rx_bit_end & rx_s;
    assign rx_frame_bad = (rx_state_q == StStop) & rx_bit_end & ~rx_s;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_tmr_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in_i};
            rx_prev_q <= rx_s;
            unique case (rx_state_q)
                StIdle: begin
                    rx_tmr_q <= '0;
                    if (rx_fall) rx_state_q <= StStart;
                end
                StStart: begin
                    if (rx_tmr_q == HalfLast) begin
                        rx_tmr_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s ? StIdle : StData;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 1'b1;
                    end
                end
                StData: begin
                    if (rx_bit_end) begin
                        rx_tmr_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= StStop;
                        else                  rx_bit_q   <= rx_bit_q + 1'b1;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 1'b1;
                    end
                end
                StStop: begin
                    if (rx_bit_end) begin
                        rx_tmr_q   <= '0;
                        rx_state_q <= StIdle;
                    end else begin
                        rx_tmr_q <= rx_tmr_q + 1'b1;
                    end
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   rx_wptr_q, rx_rptr_q;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic            rx_full, rx_empty, rx_pop, rx_push_ok, rx_overrun_set;
    logic [7:0]      rx_head;

    assign rx_full        = (rx_cnt_q == DepthCnt);
    assign rx_empty       = (rx_cnt_q == '0);
    assign rx_pop         = rd_i & sel_rx & ~rx_empty;
    // A same-cycle bus pop frees the slot the receiver needs.
    assign rx_push_ok     = rx_push & (~rx_full | rx_pop);
    assign rx_overrun_set = rx_push & rx_full & ~rx_pop;
    assign rx_head        = rx_mem_q[rx_rptr_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push_ok && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end else if (!rx_push_ok && rx_pop) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push_ok) begin
            rx_mem_q[rx_wptr_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push_ok) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)     rx_rptr_q <= rx_rptr_q + 1'b1;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // ---------------- CTRL, sticky flags, irq ----------------
    logic [1:0] ctrl_q;
    logic       rx_ovr_q, tx_ovf_q, frame_err_q, irq_q;
    logic [7:0] status;

    assign status = {frame_err_q, tx_ovf_q, tx_busy, rx_ovr_q,
                     rx_full, rx_empty, tx_empty, tx_full};
    assign irq_o  = irq_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q      <= '0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_i && sel_ctrl) begin
                ctrl_q <= wdata_i[1:0];
                if (wdata_i[4]) begin
                    rx_ovr_q    <= 1'b0;
                    tx_ovf_q    <= 1'b0;
                    frame_err_q <= 1'b0;
                end
            end
            // New events win over a same-cycle clear.
            if (rx_overrun_set)           rx_ovr_q    <= 1'b1;
            if (wr_i && sel_tx && tx_full) tx_ovf_q    <= 1'b1;
            if (rx_frame_bad)             frame_err_q <= 1'b1;
            irq_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rd_i) begin
            if (sel_rx && !rx_empty) rdata_o = {24'b0, rx_head};
            else if (sel_stat)       rdata_o = {24'b0, status};
            else if (sel_ctrl)       rdata_o = {30'b0, ctrl_q};
        end
    end
endmodule

// File: doc/uart_fifo_periph.md
UART_FIFO_PERIPH -- requirements
Module: uart_fifo_periph

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit, minimum 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX/RX FIFO, power of two, minimum 2.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h4000_0018, meaning word-aligned base of the 4-register window.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports rd and wr, input, 1 bit each: bus read and write strobes; each cycle asserted counts as one access.
REQ-007 SHALL have ports addr and wdata, input, 32 bits each: byte address and write data.
REQ-008 SHALL have port rdata, output, 32 bits: combinational read data; all zero when rd=0 or addr is outside the window, so it can be OR-combined with other peripherals.
REQ-009 SHALL have ports rx_in (input, 1 bit, asynchronous serial in) and tx_out (output, 1 bit, serial out, idle high).
REQ-010 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-011 SHALL decode this register map, with any other address not selected:
- BASE+0 TXDATA: write pushes wdata[7:0]; read returns 0.
- BASE+4 RXDATA: read returns {24'b0, head} and pops.
- BASE+8 STATUS, read-only: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun, bit5 tx_busy, bit6 tx_overflow, bit7 frame_err.
- BASE+C CTRL: bit0 rx_irq_en, bit1 tx_irq_en, read back in bits[1:0]; a write with wdata[4]=1 clears sticky bits 4, 6 and 7.
REQ-012 SHALL implement each FIFO as circular read/write pointers plus a count.
- Pointers wrap modulo FIFO_DEPTH.
- full is count==FIFO_DEPTH; empty is count==0.
REQ-013 SHALL ignore a TXDATA write while tx_full and set tx_overflow.
REQ-014 SHALL return 0 for an RXDATA read while rx_empty and leave the pointers unchanged.
REQ-015 SHALL perform a push and a pop on the same FIFO in the same cycle together, leaving count unchanged.
- On a full RX FIFO, a simultaneous bus pop lets the receiver's push succeed.
REQ-016 SHALL run a TX FSM with states IDLE -> START -> DATA -> STOP -> IDLE, framing 8N1, LSB first, each bit held exactly CLKS_PER_BIT cycles.
- In IDLE with a non-empty TX FIFO: pop and enter START on the next edge.
- Back-to-back bytes: no idle gap.
REQ-017 SHALL assert tx_busy whenever the TX FSM is not in IDLE.
REQ-018 SHALL pass rx_in through a 2-flop synchroniser before any RX logic.
REQ-019 SHALL run an RX FSM with states IDLE -> START -> DATA -> STOP -> IDLE.
- A falling edge in IDLE starts the frame.
- The start bit is sampled at CLKS_PER_BIT/2; if high, return to IDLE as a glitch.
- Data bits and the stop bit are sampled every CLKS_PER_BIT thereafter.
REQ-020 SHALL handle the RX stop bit and FIFO state as follows:
- Stop bit sampled low: discard the byte and set frame_err.
- Otherwise, push into the RX FIFO.
- RX FIFO full with no simultaneous pop: drop the byte and set rx_overrun.
REQ-021 SHALL drive irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy), registered, one cycle latency.

Reset
REQ-022 SHALL, in the cycle reset is sampled high, regardless of any frame in progress:
- clear both FIFOs, pointers, counts, CTRL and all sticky flags;
- return both FSMs to IDLE;
- set tx_out=1, irq=0 and the synchroniser flops to 1.
REQ-023 SHALL give reset priority over simultaneous rd/wr.

Verification
REQ-024 SHALL cover TX of a single byte: CLKS_PER_BIT=4, write 0x55 to TXDATA -> tx_out shows 0,1,0,1,0,1,0,1,0,1 (start, 8 data bits LSB first, stop), each for 4 cycles, then tx_busy=0 and tx_empty=1.
REQ-025 SHALL cover RX and pop: drive 8N1 frame 0xA3 on rx_in -> STATUS bit2=0, then RXDATA read returns 0x000000A3 and STATUS bit2 returns to 1.
REQ-026 SHALL cover RX overrun: FIFO_DEPTH=4, receive 5 frames without reading -> rx_full=1, rx_overrun=1, then 4 reads return the first 4 bytes in order.
REQ-027 SHALL cover TX overflow: FIFO_DEPTH=4, issue 6 back-to-back TXDATA writes -> the first byte is popped on the first IDLE-state cycle, so 5 accepted and 1 dropped, tx_overflow=1; a CTRL write of 0x10 clears it.
REQ-028 SHALL cover interrupts: CTRL=0x1 then receive a byte -> irq=1 within 1 cycle of the push; a read drains the FIFO -> irq=0 next cycle.
REQ-029 SHALL cover reset mid-frame: assert reset during the DATA state -> tx_out=1 on the next edge, STATUS reads 0x00000006, no stale byte is later transmitted.
